mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's control path.
- Services the single-word `read`/`write` requests issued by the control FSM: writes complete in one cycle, reads return after a fixed, parameterised latency with a one-cycle `rvalid` pulse.
- Holds the data memory array internally.
- Sits between the datapath (address/write-data from the register file, read data to the write-back mux) and the control FSM, which waits on `rvalid` before writing back.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words.
- DATA_W, 16, data word width.
- READ_LATENCY, 2, cycles from the read-accept edge to the `rvalid` cycle; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  ADDR_W  word address, sampled on the accept edge.
- read  input  1  read request.
- write  input  1  write request.
- wdata  input  DATA_W  write data, sampled on the accept edge.
- waitrequest  output  1  high = request not accepted this cycle.
- rdata  output  DATA_W  read data; valid when `rvalid` = 1, held otherwise.
- rvalid  output  1  one-cycle read-response pulse.
- err  output  1  one-cycle pulse flagging a protocol violation.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; `waitrequest` = 0, `rvalid` = 0, `rdata` = 0, `err` = 0, latency counter = 0.
  - Memory array is NOT cleared.
- States: IDLE, READ_WAIT, READ_RESP.
- `waitrequest` is combinational: 1 in every state except IDLE.
- A request is accepted only on a rising edge where the state is IDLE and `read` or `write` is high. Requests made while `waitrequest` = 1 are ignored: no memory change, no response, no `err`.
- Write (IDLE, `write` = 1, `read` = 0):
  - `mem[addr]` <= `wdata` on the accept edge; state stays IDLE.
  - No response pulse. Back-to-back writes are allowed every cycle.
- Read (IDLE, `read` = 1, `write` = 0):
  - On the accept edge, `mem[addr]` is captured into an internal data register.
  - If READ_LATENCY = 1, go to READ_RESP.
  - Otherwise go to READ_WAIT with counter <= READ_LATENCY-2.
- READ_WAIT: counter decrements each edge; when counter = 0, go to READ_RESP.
- READ_RESP:
  - `rvalid` = 1 and `rdata` = captured word for exactly this one cycle.
  - Next edge goes to IDLE.
- Read timing: a read accepted at edge N has `rvalid` high during the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after accept. Read throughput is one read per READ_LATENCY+1 cycles.
- `rdata` is registered. It updates only when entering READ_RESP and holds its value until the next read response.
- Simultaneous `read` = 1 and `write` = 1 in IDLE:
  - Treated as a write only; the read is dropped.
  - `err` pulses high for the cycle after the accept edge.
- Address boundaries: every `addr` value is in range; address 2**ADDR_W-1 is an ordinary word. There is no wrap and no out-of-range case.
- Reset mid-read (in READ_WAIT or READ_RESP):
  - Response is aborted, `rvalid` goes to 0 immediately, state goes to IDLE.
  - No `rvalid` is ever produced for the aborted read.
- Read-after-write: a write at edge N followed by a read accepted at edge N+1 to the same address returns the new data.

Test Plan:
- Defaults (READ_LATENCY = 2): write addr 0x10 = 0xBEEF, then read 0x10 accepted at edge N → `waitrequest` = 1 for 2 cycles after N; `rvalid` high for exactly 1 cycle after edge N+1 with `rdata` = 0xBEEF; `rdata` still 0xBEEF afterwards.
- Back-to-back writes 0x00 = 0x1111, 0xFF = 0x2222 on consecutive cycles, then read both → 0x1111 and 0x2222 returned; `waitrequest` stays 0 throughout the writes.
- During READ_WAIT, assert `write` addr 0x10 = 0x0000 → ignored; a subsequent read of 0x10 still returns 0xBEEF; `err` stays 0.
- IDLE with `read` = `write` = 1, addr 0x20, `wdata` 0xA5A5 → `err` pulses 1 cycle, no `rvalid`; a later read of 0x20 returns 0xA5A5.
- Assert `reset` one cycle after a read is accepted → `rvalid` never rises; `waitrequest` = 0 immediately; contents written before reset are still readable afterwards.
- Rebuild with READ_LATENCY = 1: read at edge N → `rvalid` in the cycle after edge N; next read accepted at edge N+2.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the control FSM (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic              waitrequest;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;

    modport master (
        output addr, read, write, wdata,
        input  waitrequest, rdata, rvalid, err
    );

    modport slave (
        input  addr, read, write, wdata,
        output waitrequest, rdata, rvalid, err
    );
endinterface

// File: rtl/mem_responder.sv
// Data-memory responder: single-cycle writes, fixed-latency reads with a one-cycle
// rvalid pulse, and a one-cycle err pulse when read and write are requested together.
module mem_responder #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2   // 1..15
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        READ_RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    // Wait-state count loaded on accept; READ_WAIT spends CNT_INIT+1 cycles.
    localparam logic [3:0] CNT_INIT = 4'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;    // word captured on the read-accept edge
    logic [DATA_W-1:0] rdata_q, rdata_d;  // registered response word, held between reads
    logic              err_q, err_d;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rd_word = mem_q[bus.addr];

    // Memory write port; the array deliberately keeps its contents across reset.
    // NOTE: memory arrays get no reset branch -- a reset would force them into flops
    // instead of RAM and would also destroy contents that must survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.addr] <= bus.wdata;
        end
    end

    // State and response registers with asynchronous active-high reset.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept requests only in IDLE, count down the read latency.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.write) begin
                    // A write wins over a simultaneous read; the dropped read is flagged.
                    mem_we = 1'b1;
                    err_d  = bus.read;
                end else if (bus.read) begin
                    data_d = rd_word;
                    if (READ_LATENCY == 1) begin
                        state_d = READ_RESP;
                        rdata_d = rd_word;
                    end else begin
                        state_d = READ_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            READ_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = READ_RESP;
                    rdata_d = data_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READ_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.waitrequest = (state_q != IDLE);
    assign bus.rvalid      = (state_q == READ_RESP);
    assign bus.rdata       = rdata_q;
    assign bus.err         = err_q;
endmodule
